sha2_msg_schedule: RTL and testbench

Message-schedule generator for the SHA-2 datapath. It accepts one 16-word message block over a valid/ready input. It then streams the schedule words W0..W(ROUNDS-1), one per handshake, to the round-compression stage, which consumes one Wj per round. One instance serves SHA-224/256 (WORDSIZE=32, ROUNDS=64) or SHA-384/512 (WORDSIZE=64, ROUNDS=80).

---
 rtl/sha2_msg_schedule.sv | 137 +++++++++++++
 tb/tb_sha2_msg_schedule.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_msg_schedule.sv
// sha2_msg_schedule
// Message-schedule generator for the SHA-2 datapath.
// Loads one 16-word block, then streams W0..W(ROUNDS-1) one per handshake.
// WORDSIZE=32 serves SHA-224/256, WORDSIZE=64 serves SHA-384/512.
//
// Handshake rule for both ports: a transfer happens on a rising edge where
// valid and ready are both high. A producer holds valid and its payload stable
// until that transfer. Here m_ready and w_valid come only from the state
// register, so neither port has a combinational path from its inputs.

module sha2_msg_schedule #(
  parameter int WORDSIZE = 32,
  parameter int ROUNDS   = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m_valid,
  output logic                m_ready,
  input  logic [WORDSIZE-1:0] m_word,
  output logic                w_valid,
  input  logic                w_ready,
  output logic [WORDSIZE-1:0] w_data,
  output logic [6:0]          w_index,
  output logic                w_last
);

  // Reject configurations the sigma functions or the 7-bit index cannot cover.
  generate
    if (!(WORDSIZE == 32 || WORDSIZE == 64)) begin : g_bad_wordsize
      $error("sha2_msg_schedule: WORDSIZE must be 32 or 64");
    end
    if (ROUNDS < 16 || ROUNDS > 80) begin : g_bad_rounds
      $error("sha2_msg_schedule: ROUNDS must be in 16..80");
    end
  endgenerate

  // Rotate and shift amounts for the small sigma functions.
  localparam int S0_R1 = (WORDSIZE == 64) ? 1  : 7;
  localparam int S0_R2 = (WORDSIZE == 64) ? 8  : 18;
  localparam int S0_SH = (WORDSIZE == 64) ? 7  : 3;
  localparam int S1_R1 = (WORDSIZE == 64) ? 19 : 17;
  localparam int S1_R2 = (WORDSIZE == 64) ? 61 : 19;
  localparam int S1_SH = (WORDSIZE == 64) ? 6  : 10;

  localparam logic [6:0] LOAD_LAST = 7'd15;
  localparam logic [6:0] RUN_LAST  = 7'(ROUNDS - 1);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The current state is kept as a named register so checkers can observe it.
  state_t              state;
  logic [6:0]          cnt;
  logic [WORDSIZE-1:0] win [16];
  logic [WORDSIZE-1:0] new_word;
  logic                m_fire;
  logic                w_fire;

  function automatic logic [WORDSIZE-1:0] rotr(input logic [WORDSIZE-1:0] x,
                                               input int n);
    return (x >> n) | (x << (WORDSIZE - n));
  endfunction

  function automatic logic [WORDSIZE-1:0] sigma0(input logic [WORDSIZE-1:0] x);
    return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
  endfunction

  function automatic logic [WORDSIZE-1:0] sigma1(input logic [WORDSIZE-1:0] x);
    return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
  endfunction

  // Next schedule word W(t+16) from the window holding W(t)..W(t+15).
  always_comb begin
    new_word = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
  end

  // m_valid is only accepted in LOAD, w_ready is only accepted in RUN.
  always_comb begin
    m_fire = (state == LOAD) && m_valid;
    w_fire = (state == RUN) && w_ready;
  end

  // Outputs are decoded from registers only; w_data is the oldest window entry.
  always_comb begin
    m_ready = (state == LOAD);
    w_valid = (state == RUN);
    w_data  = win[0];
    w_index = cnt;
    w_last  = (state == RUN) && (cnt == RUN_LAST);
  end

  // State, counter and window. Reset wins over any handshake at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      cnt   <= 7'd0;
      for (int i = 0; i < 16; i++) begin
        win[i] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (m_fire) begin
            win[cnt[3:0]] <= m_word;
            if (cnt == LOAD_LAST) begin
              cnt   <= 7'd0;
              state <= RUN;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
        end
        RUN: begin
          if (w_fire) begin
            for (int i = 0; i < 15; i++) begin
              win[i] <= win[i+1];
            end
            win[15] <= new_word;
            if (cnt == RUN_LAST) begin
              cnt   <= 7'd0;
              state <= LOAD;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
        end
        default: begin
          state <= LOAD;
          cnt   <= 7'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha2_msg_schedule.sv
// Testbench for sha2_msg_schedule: one SHA-256 and one SHA-512 instance.
// A reference schedule model fills exp_q at load time; words are popped and
// compared as the DUT hands them out.

module tb_sha2_msg_schedule;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic        sel;        // 0 = SHA-256 instance, 1 = SHA-512 instance
  logic        m_valid;
  logic [63:0] m_word;
  logic        w_ready;

  logic        m_ready_256, w_valid_256, w_last_256;
  logic [31:0] w_data_256;
  logic [6:0]  w_index_256;
  logic        m_ready_512, w_valid_512, w_last_512;
  logic [63:0] w_data_512;
  logic [6:0]  w_index_512;

  logic        cur_m_ready, cur_w_valid, cur_w_last;
  logic [63:0] cur_w_data;
  logic [6:0]  cur_w_index;

  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  logic [63:0] spot16, spot17;
  bit          spot16_en = 0, spot17_en = 0;

  sha2_msg_schedule #(.WORDSIZE(32), .ROUNDS(64)) dut_256 (
    .clk     (clk),
    .rst     (rst),
    .m_valid (m_valid & ~sel),
    .m_ready (m_ready_256),
    .m_word  (m_word[31:0]),
    .w_valid (w_valid_256),
    .w_ready (w_ready),
    .w_data  (w_data_256),
    .w_index (w_index_256),
    .w_last  (w_last_256)
  );

  sha2_msg_schedule #(.WORDSIZE(64), .ROUNDS(80)) dut_512 (
    .clk     (clk),
    .rst     (rst),
    .m_valid (m_valid & sel),
    .m_ready (m_ready_512),
    .m_word  (m_word),
    .w_valid (w_valid_512),
    .w_ready (w_ready),
    .w_data  (w_data_512),
    .w_index (w_index_512),
    .w_last  (w_last_512)
  );

  always_comb begin
    if (sel) begin
      cur_m_ready = m_ready_512;
      cur_w_valid = w_valid_512;
      cur_w_data  = w_data_512;
      cur_w_index = w_index_512;
      cur_w_last  = w_last_512;
    end else begin
      cur_m_ready = m_ready_256;
      cur_w_valid = w_valid_256;
      cur_w_data  = {32'b0, w_data_256};
      cur_w_index = w_index_256;
      cur_w_last  = w_last_256;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  function automatic logic [31:0] s0_32(input logic [31:0] x);
    return ror32(x, 7) ^ ror32(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1_32(input logic [31:0] x);
    return ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [63:0] s0_64(input logic [63:0] x);
    return ror64(x, 1) ^ ror64(x, 8) ^ (x >> 7);
  endfunction
  function automatic logic [63:0] s1_64(input logic [63:0] x);
    return ror64(x, 19) ^ ror64(x, 61) ^ (x >> 6);
  endfunction

  task automatic push_expected(input logic [63:0] blk[16]);
    logic [63:0] w [80];
    logic [31:0] a, b, c, d;
    int rounds;
    rounds = sel ? 80 : 64;
    for (int t = 0; t < 16; t++) w[t] = sel ? blk[t] : {32'b0, blk[t][31:0]};
    for (int t = 16; t < 80; t++) begin
      if (sel) begin
        w[t] = s1_64(w[t-2]) + w[t-7] + s0_64(w[t-15]) + w[t-16];
      end else begin
        a = w[t-2][31:0];
        b = w[t-7][31:0];
        c = w[t-15][31:0];
        d = w[t-16][31:0];
        a = s1_32(a) + b + s0_32(c) + d;
        w[t] = {32'b0, a};
      end
    end
    for (int t = 0; t < rounds; t++) exp_q.push_back(w[t]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_block(input logic [63:0] blk[16], input bit gaps);
    push_expected(blk);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          m_valid = 1'b0;
          w_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
      m_valid = 1'b1;
      m_word  = blk[i];
      n_checks++;
      if (cur_m_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL m_ready_load word %0d: got %b expected 1", i, cur_m_ready);
      end
      n_checks++;
      if (cur_w_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL w_valid_load word %0d: got %b expected 0", i, cur_w_valid);
      end
      @(negedge clk);
    end
    m_valid = 1'b0;
    m_word  = '0;
    n_checks++;
    if (cur_w_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL w_valid_latency: got %b expected 1", cur_w_valid);
    end
  endtask

  // mode 0: full rate, 1: 3-cycle stall at index 20, 2: random w_ready.
  // Stops once stop_at words have been handed over.
  task automatic run_block(input int mode, input bit junk, input int stop_at);
    int rounds, exp_idx, cycles, stall;
    bit stalled_once;
    logic [63:0] exp_w;
    rounds = sel ? 80 : 64;
    exp_idx = 0; cycles = 0; stall = 0; stalled_once = 0;
    while (exp_idx < stop_at && cycles < 1000) begin
      cycles++;
      if (mode == 1 && !stalled_once && cur_w_valid && cur_w_index == 7'd20) begin
        stall = 3;
        stalled_once = 1;
      end
      if (mode == 2) w_ready = 1'($urandom_range(0, 1));
      else if (stall > 0) begin
        w_ready = 1'b0;
        stall--;
      end else w_ready = 1'b1;
      if (junk) begin
        m_valid = 1'b1;
        m_word  = {$urandom(), $urandom()};
        n_checks++;
        if (cur_m_ready !== 1'b0) begin
          n_errors++;
          $display("FAIL m_ready_run idx %0d: got %b expected 0", exp_idx, cur_m_ready);
        end
      end
      n_checks++;
      if (cur_w_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL w_valid_run idx %0d: got %b expected 1", exp_idx, cur_w_valid);
        break;
      end
      exp_w = (exp_q.size() > 0) ? exp_q[0] : 64'hx;
      n_checks++;
      if (cur_w_data !== exp_w) begin
        n_errors++;
        $display("FAIL w_data idx %0d ready %b: got %h expected %h", exp_idx, w_ready, cur_w_data, exp_w);
      end
      n_checks++;
      if (cur_w_index !== 7'(exp_idx)) begin
        n_errors++;
        $display("FAIL w_index: got %0d expected %0d", cur_w_index, exp_idx);
      end
      n_checks++;
      if (cur_w_last !== (exp_idx == rounds - 1)) begin
        n_errors++;
        $display("FAIL w_last idx %0d: got %b expected %b", exp_idx, cur_w_last, exp_idx == rounds - 1);
      end
      if (w_ready) begin
        if (spot16_en && exp_idx == 16) begin
          n_checks++;
          if (cur_w_data !== spot16) begin
            n_errors++;
            $display("FAIL W16_const: got %h expected %h", cur_w_data, spot16);
          end
        end
        if (spot17_en && exp_idx == 17) begin
          n_checks++;
          if (cur_w_data !== spot17) begin
            n_errors++;
            $display("FAIL W17_const: got %h expected %h", cur_w_data, spot17);
          end
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        exp_idx++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (exp_idx < stop_at) begin
      n_errors++;
      $display("FAIL run_timeout: got %0d words expected %0d", exp_idx, stop_at);
    end
    if (junk) m_valid = 1'b0;
    if (stop_at == rounds) begin
      m_valid = 1'b0;
      w_ready = 1'b0;
      n_checks++;
      if (cur_m_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL m_ready_after_last: got %b expected 1", cur_m_ready);
      end
      n_checks++;
      if (cur_w_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL w_valid_after_last: got %b expected 0", cur_w_valid);
      end
    end
  endtask

  task automatic make_abc(output logic [63:0] blk[16]);
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = sel ? 64'h6162638000000000 : 64'h0000000061626380;
    blk[15] = 64'h18;
  endtask

  task automatic make_random(output logic [63:0] blk[16]);
    for (int i = 0; i < 16; i++) blk[i] = {$urandom(), $urandom()};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    n_checks++;
    if ({m_ready_256, w_valid_256, w_last_256} !== 3'b100) begin
      n_errors++;
      $display("FAIL reset_ctrl_256: got %b expected 100", {m_ready_256, w_valid_256, w_last_256});
    end
    n_checks++;
    if (w_data_256 !== 32'h0 || w_index_256 !== 7'd0) begin
      n_errors++;
      $display("FAIL reset_data_256: got %h/%0d expected 0/0", w_data_256, w_index_256);
    end
    n_checks++;
    if ({m_ready_512, w_valid_512, w_last_512} !== 3'b100) begin
      n_errors++;
      $display("FAIL reset_ctrl_512: got %b expected 100", {m_ready_512, w_valid_512, w_last_512});
    end
    n_checks++;
    if (w_data_512 !== 64'h0 || w_index_512 !== 7'd0) begin
      n_errors++;
      $display("FAIL reset_data_512: got %h/%0d expected 0/0", w_data_512, w_index_512);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abc_full_rate;
    logic [63:0] blk[16];
    sel = 1'b0;
    make_abc(blk);
    spot16 = 64'h61626380; spot16_en = 1;
    spot17 = 64'h000F0000; spot17_en = 1;
    load_block(blk, 1'b0);
    run_block(0, 1'b0, 64);
    spot16_en = 0; spot17_en = 0;
  endtask

  task automatic test_backpressure;
    logic [63:0] blk[16];
    sel = 1'b0;
    make_abc(blk);
    load_block(blk, 1'b0);
    run_block(1, 1'b0, 64);
  endtask

  task automatic test_random;
    logic [63:0] blk[16];
    sel = 1'b0;
    make_abc(blk);
    load_block(blk, 1'b1);
    run_block(2, 1'b0, 64);
    make_random(blk);
    load_block(blk, 1'b1);
    run_block(2, 1'b0, 64);
  endtask

  task automatic test_ignored_input;
    logic [63:0] blk[16];
    sel = 1'b0;
    make_random(blk);
    load_block(blk, 1'b0);
    run_block(0, 1'b1, 64);
    // Back-to-back block right after the junk-driven run.
    make_abc(blk);
    load_block(blk, 1'b0);
    run_block(0, 1'b0, 64);
  endtask

  task automatic test_reset_mid_run;
    logic [63:0] blk[16];
    sel = 1'b0;
    make_abc(blk);
    load_block(blk, 1'b0);
    run_block(0, 1'b0, 30);
    rst = 1'b1;
    w_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    w_ready = 1'b0;
    n_checks++;
    if ({cur_m_ready, cur_w_valid, cur_w_last} !== 3'b100) begin
      n_errors++;
      $display("FAIL mid_reset_ctrl: got %b expected 100", {cur_m_ready, cur_w_valid, cur_w_last});
    end
    n_checks++;
    if (cur_w_data !== 64'h0 || cur_w_index !== 7'd0) begin
      n_errors++;
      $display("FAIL mid_reset_data: got %h/%0d expected 0/0", cur_w_data, cur_w_index);
    end
    exp_q.delete();
    load_block(blk, 1'b0);
    run_block(0, 1'b0, 64);
  endtask

  task automatic test_sha512;
    logic [63:0] blk[16];
    sel = 1'b1;
    make_abc(blk);
    spot16 = 64'h6162638000000000; spot16_en = 1;
    spot17 = 64'h00030000000000C0; spot17_en = 1;
    load_block(blk, 1'b0);
    run_block(0, 1'b0, 80);
    spot16_en = 0; spot17_en = 0;
    make_random(blk);
    load_block(blk, 1'b1);
    run_block(2, 1'b0, 80);
    sel = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    sel = 1'b0;
    rst = 1'b1;
    m_valid = 1'b0;
    m_word = '0;
    w_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    test_abc_full_rate;
    test_backpressure;
    test_random;
    test_ignored_input;
    test_reset_mid_run;
    test_sha512;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
